instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
IF stage of the 5-stage pipeline, sitting directly upstream of the IF/ID latch. It holds the PC and a word-addressed instruction memory, which the debug unit loads byte-by-byte from UART. Each pipeline advance presents the instruction at the current PC plus the next-sequential PC. Fetch stops when the end-of-program marker "ieof" (0x69656F66) is fetched on the correct path.

Parameters:
NB_INSTRUCT, 32, instruction width in bits
NB_PC, 6, PC width; PC is a word index
MEM_DEPTH, 2**NB_PC, instruction memory depth in words
NB_BYTE, 8, load byte width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_pipeline_mode  in  2  2'b01 continuous, 2'b11 stepwise, other values idle
i_run_clockcycle  in  1  step pulse, honoured only in stepwise mode
i_PC_write  in  1  0 = hazard stall, PC holds
i_PC_src  in  1  1 = redirect to i_branch_target
i_branch_target  in  NB_PC  resolved branch/jump target (word index)
i_load_start  in  1  begin a new program load; accepted in LOAD or HALT only
i_load_valid  in  1  i_load_byte valid this cycle
i_load_byte  in  NB_BYTE  program byte, most-significant byte of each word first
o_instruction  out  NB_INSTRUCT  mem[PC] in RUN/HALT, else 0 (NOP)
o_PC  out  NB_PC  PC+1, mod 2**NB_PC
o_load_done  out  1  load finished with eof stored
o_load_error  out  1  memory filled with no eof found
o_halted  out  1  state is HALT
o_state  out  2  FSM state, for the debug unit

Behaviour:
- Reset (async): PC=0, state=LOAD, byte count=0, write pointer=0, word assembler=0, o_load_done=0, o_load_error=0. Outputs read o_instruction=0, o_PC=1, o_halted=0. Memory contents are not cleared.
- FSM states: LOAD=0, READY=1, RUN=2, HALT=3.
- LOAD:
  - Each i_load_valid shifts i_load_byte into the assembler from the LSB side and increments the 2-bit byte count.
  - On the 4th byte, the complete word is written to mem[wptr] on that clock edge, and wptr increments.
  - If the completed word equals "ieof": o_load_done=1 and the next state is READY.
  - If wptr was MEM_DEPTH-1 and the word is not eof: o_load_error=1, next state READY, wptr does not wrap.
  - i_load_start in LOAD clears wptr, byte count, o_load_done and o_load_error.
- READY: moves to RUN when i_pipeline_mode is 01 or 11. PC stays 0.
- advance = (state==RUN) and (mode==01 or (mode==11 and i_run_clockcycle)). In mode 00 or 10 there is no advance, and the block stays in RUN.
- Memory read is combinational (zero latency): o_instruction = mem[PC] in the same cycle. The IF/ID latch captures it on the same edge that updates the PC.
- On each advance edge:
  - If i_PC_write=0: PC holds (stall), no halt check.
  - Else if i_PC_src=1: PC <= i_branch_target; redirect wins over eof, so a wrong-path eof does not halt.
  - Else if mem[PC]==eof: state <= HALT and PC holds at the eof word.
  - Else: PC <= PC+1, wrapping from MEM_DEPTH-1 to 0.
- HALT: PC frozen; o_instruction keeps driving eof, so the downstream EOF flag stays set. i_load_start returns the block to LOAD and clears PC, wptr, byte count, o_load_done and o_load_error.
- i_load_valid outside LOAD is ignored. i_load_start in READY or RUN is ignored.
- Reset mid-load or mid-run: immediate return to the reset state. Any partially assembled word is discarded.

Decomposition:
- Shared package: INSTR_EOF constant (32'h69656F66), CONT_MOD (2'b01) and STEP_MOD (2'b11) codes, FSM state encodings. The IF/ID latch uses the same package.
- Sub-module instruction_memory: MEM_DEPTH x NB_INSTRUCT, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata).
- This module contains the FSM, PC register, byte assembler and advance logic.

Test Plan:
- Load 3 words 0x20010005, 0x20020003, "ieof" (12 bytes, MSB first), then mode=01 -> o_load_done=1; o_instruction sequence 0x20010005, 0x20020003, 0x69656F66; o_PC 1, 2, 3; then o_halted=1 with PC held at 2.
- Mode=11, single i_run_clockcycle pulses -> PC advances exactly once per pulse; with no pulse for 10 cycles, PC stays constant.
- Continuous run, i_PC_write=0 for 2 cycles at PC=1 -> PC holds at 1 and o_instruction is stable; PC resumes at 2 after release.
- PC=2 holding eof with i_PC_src=1, target=0 on the same advance -> no halt, PC=0, state stays RUN.
- Load 64 non-eof words (NB_PC=6) -> o_load_error=1, o_load_done=0, state READY, wptr stops at 63.
- Assert i_reset after 2 of 4 bytes, then reload a full program -> first stored word is correct, with no stale bytes in the assembler. From HALT, pulse i_load_start -> state LOAD and PC=0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared IF-stage definitions: end-of-program marker, run modes, FSM states.
// Imported by the fetch stage and the IF/ID latch.
package instruction_fetch_pkg;

  localparam logic [31:0] INSTR_EOF = 32'h69656F66;

  localparam logic [1:0] CONT_MOD = 2'b01;
  localparam logic [1:0] STEP_MOD = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } if_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Instruction RAM: synchronous write port, asynchronous read port.
// Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 6,
  parameter int DEPTH   = 2**NB_ADDR
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, byte-wise program loader and fetch FSM over instruction_memory.
// Ports: i_clk/i_reset, run control (i_pipeline_mode, i_run_clockcycle,
//   i_PC_write, i_PC_src, i_branch_target), loader (i_load_start,
//   i_load_valid, i_load_byte), outputs o_instruction, o_PC (PC+1),
//   o_load_done, o_load_error, o_halted, o_state.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NB_INSTRUCT = 32,
  parameter int NB_PC       = 6,
  parameter int MEM_DEPTH   = 2**NB_PC,
  parameter int NB_BYTE     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [1:0]             i_pipeline_mode,
  input  logic                   i_run_clockcycle,
  input  logic                   i_PC_write,
  input  logic                   i_PC_src,
  input  logic [NB_PC-1:0]       i_branch_target,
  input  logic                   i_load_start,
  input  logic                   i_load_valid,
  input  logic [NB_BYTE-1:0]     i_load_byte,
  output logic [NB_INSTRUCT-1:0] o_instruction,
  output logic [NB_PC-1:0]       o_PC,
  output logic                   o_load_done,
  output logic                   o_load_error,
  output logic                   o_halted,
  output logic [1:0]             o_state
);

  localparam int NB_ASM = NB_INSTRUCT - NB_BYTE;
  localparam logic [NB_INSTRUCT-1:0] W_EOF =
    NB_INSTRUCT'(INSTR_EOF);
  localparam logic [NB_PC-1:0] LAST_ADDR =
    NB_PC'(MEM_DEPTH - 1);

  if_state_t               r_state;
  logic [NB_PC-1:0]        r_pc;
  logic [NB_PC-1:0]        r_wptr;
  logic [1:0]              r_bcnt;
  logic [NB_ASM-1:0]       r_asm;
  logic                    r_load_done;
  logic                    r_load_error;

  logic [NB_INSTRUCT-1:0]  w_word;
  logic [NB_INSTRUCT-1:0]  w_rdata;
  logic                    w_we;
  logic                    w_word_eof;
  logic                    w_fetch_eof;
  logic                    w_mode_ok;
  logic                    w_advance;

  // Bytes arrive MSB first, so each new byte enters at the LSB end.
  assign w_word = {r_asm, i_load_byte};
  assign w_word_eof = (w_word == W_EOF);

  assign w_we = (r_state == ST_LOAD) && i_load_valid
             && !i_load_start && (r_bcnt == 2'd3);

  assign w_mode_ok = (i_pipeline_mode == CONT_MOD)
                  || (i_pipeline_mode == STEP_MOD);

  assign w_advance = (r_state == ST_RUN)
    && ((i_pipeline_mode == CONT_MOD)
     || ((i_pipeline_mode == STEP_MOD) && i_run_clockcycle));

  assign w_fetch_eof = (w_rdata == W_EOF);

  instruction_memory #(
    .NB_DATA (NB_INSTRUCT),
    .NB_ADDR (NB_PC),
    .DEPTH   (MEM_DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_word),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_LOAD;
      r_pc         <= '0;
      r_wptr       <= '0;
      r_bcnt       <= '0;
      r_asm        <= '0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (i_load_start) begin
            r_wptr       <= '0;
            r_bcnt       <= '0;
            r_asm        <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
          end else if (i_load_valid) begin
            r_asm  <= w_word[NB_ASM-1:0];
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              // Pointer saturates at the last slot.
              if (r_wptr != LAST_ADDR)
                r_wptr <= r_wptr + 1'b1;
              if (w_word_eof) begin
                r_load_done <= 1'b1;
                r_state     <= ST_READY;
              end else if (r_wptr == LAST_ADDR) begin
                r_load_error <= 1'b1;
                r_state      <= ST_READY;
              end
            end
          end
        end
        ST_READY: begin
          if (w_mode_ok) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Redirect beats eof: a wrong-path eof must not halt.
          if (w_advance && i_PC_write) begin
            if (i_PC_src)
              r_pc <= i_branch_target;
            else if (w_fetch_eof)
              r_state <= ST_HALT;
            else
              r_pc <= r_pc + 1'b1;
          end
        end
        ST_HALT: begin
          if (i_load_start) begin
            r_state      <= ST_LOAD;
            r_pc         <= '0;
            r_wptr       <= '0;
            r_bcnt       <= '0;
            r_asm        <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign o_instruction = ((r_state == ST_RUN) || (r_state == ST_HALT))
                       ? w_rdata : '0;
  assign o_PC         = r_pc + 1'b1;
  assign o_load_done  = r_load_done;
  assign o_load_error = r_load_error;
  assign o_halted     = (r_state == ST_HALT);
  assign o_state      = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural model checked every cycle
// plus hand-computed expectations at key points of directed scenarios.
module tb_instruction_fetch;

  localparam logic [31:0] EOF = 32'h69656F66;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        run = 1'b0;
  logic        pc_write = 1'b1;
  logic        pc_src = 1'b0;
  logic [5:0]  target = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic [31:0] instr;
  logic [5:0]  opc;
  logic        done;
  logic        err;
  logic        halted;
  logic [1:0]  state;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_pipeline_mode  (mode),
    .i_run_clockcycle (run),
    .i_PC_write       (pc_write),
    .i_PC_src         (pc_src),
    .i_branch_target  (target),
    .i_load_start     (ld_start),
    .i_load_valid     (ld_valid),
    .i_load_byte      (ld_byte),
    .o_instruction    (instr),
    .o_PC             (opc),
    .o_load_done      (done),
    .o_load_error     (err),
    .o_halted         (halted),
    .o_state          (state)
  );

  // Model: 0 load, 1 ready, 2 run, 3 halt
  logic [31:0] mm [64];
  logic [7:0]  mq [$];
  int m_st = 0;
  int m_pc = 0;
  int m_wcnt = 0;
  bit m_done = 0;
  bit m_err = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_load();
    mq.delete();
    m_wcnt = 0;
    m_done = 0;
    m_err = 0;
  endtask

  always @(posedge clk) begin
    logic [31:0] w;
    bit adv;
    if (rst) begin
      clear_load();
      m_st = 0;
      m_pc = 0;
    end else begin
      case (m_st)
        0: begin
          if (ld_start) clear_load();
          else if (ld_valid) begin
            mq.push_back(ld_byte);
            if (mq.size() == 4) begin
              w = {mq[0], mq[1], mq[2], mq[3]};
              mq.delete();
              mm[m_wcnt] = w;
              if (w == EOF) begin
                m_done = 1; m_st = 1;
              end else if (m_wcnt == 63) begin
                m_err = 1; m_st = 1;
              end
              if (m_wcnt < 63) m_wcnt++;
            end
          end
        end
        1: if (mode == 2'b01 || mode == 2'b11) m_st = 2;
        2: begin
          adv = (mode == 2'b01) || (mode == 2'b11 && run);
          if (adv && pc_write) begin
            if (pc_src) m_pc = int'(target);
            else if (mm[m_pc] == EOF) m_st = 3;
            else m_pc = (m_pc + 1) % 64;
          end
        end
        default: if (ld_start) begin
          clear_load();
          m_st = 0;
          m_pc = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] ei;
    if (chk_en) begin
      ei = (m_st >= 2) ? mm[m_pc] : 32'h0;
      check("model_instr", instr, ei);
      check("model_pc", 32'(opc), 32'((m_pc + 1) % 64));
      check("model_state", 32'(state), 32'(m_st));
      check("model_halted", 32'(halted), 32'(m_st == 3));
      check("model_done", 32'(done), 32'(m_done));
      check("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_word(logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic step_once();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    ticks(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_opc", 32'(opc), 32'd1);
    check("reset_state", 32'(state), 32'd0);
    check("reset_instr", instr, 32'h0);
    check("reset_done", 32'(done), 32'd0);

    // Basic program, continuous run to halt
    pulse_start();
    load_word(32'h20010005);
    load_word(32'h20020003);
    load_word(EOF);
    check("load_done", 32'(done), 32'd1);
    check("load_ready", 32'(state), 32'd1);
    mode = 2'b01;
    tick();
    check("run_i0", instr, 32'h20010005);
    check("run_pc0", 32'(opc), 32'd1);
    tick();
    check("run_i1", instr, 32'h20020003);
    check("run_pc1", 32'(opc), 32'd2);
    tick();
    check("run_i2", instr, EOF);
    check("run_pc2", 32'(opc), 32'd3);
    tick();
    check("halted", 32'(halted), 32'd1);
    ticks(3);
    check("halt_pc", 32'(opc), 32'd3);
    check("halt_instr", instr, EOF);

    // Reload from HALT, stepwise mode
    mode = 2'b00;
    pulse_start();
    check("restart_state", 32'(state), 32'd0);
    check("restart_opc", 32'(opc), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    load_word(32'h20010005);
    load_word(32'h20020003);
    load_word(EOF);
    mode = 2'b11;
    tick();
    ticks(10);
    check("step_idle", 32'(opc), 32'd1);
    step_once();
    check("step_1", 32'(opc), 32'd2);
    ticks(2);
    step_once();
    check("step_2", 32'(opc), 32'd3);

    // Redirect on an eof fetch
    pc_src = 1'b1;
    target = 6'd0;
    step_once();
    pc_src = 1'b0;
    check("redir_pc", 32'(opc), 32'd1);
    check("redir_state", 32'(state), 32'd2);

    // Stall in continuous mode
    mode = 2'b01;
    tick();
    check("stall_pre", 32'(opc), 32'd2);
    pc_write = 1'b0;
    ticks(2);
    check("stall_pc", 32'(opc), 32'd2);
    check("stall_instr", instr, 32'h20020003);
    pc_write = 1'b1;
    tick();
    check("stall_resume", 32'(opc), 32'd3);
    tick();
    check("stall_halt", 32'(halted), 32'd1);

    // Reset with a half-assembled word
    mode = 2'b00;
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_word(32'h11223344);
    load_word(EOF);
    check("reload_done", 32'(done), 32'd1);
    mode = 2'b01;
    tick();
    check("reload_i0", instr, 32'h11223344);
    ticks(2);
    check("reload_halt", 32'(halted), 32'd1);

    // Memory full without eof
    mode = 2'b00;
    pulse_start();
    for (int i = 0; i < 64; i++) load_word(32'hA0000000 | i);
    check("full_err", 32'(err), 32'd1);
    check("full_done", 32'(done), 32'd0);
    check("full_state", 32'(state), 32'd1);
    pulse_start();
    load_word(EOF);
    check("ready_ignore", 32'(state), 32'd1);
    mode = 2'b01;
    ticks(5);
    check("full_i4", instr, 32'hA0000004);
    mode = 2'b00;
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
